test_module_dff: RTL and testbench

Free-running synchronous up-counter built from asynchronously reset D flip-flops, used as a timing-characterisation target for flop-to-flop paths. Reset assertion clears all state immediately; reset release passes through a two-flop synchroniser before counting starts. Alongside the binary count the block produces a Gray-coded copy, a terminal-count flag, a one-cycle wrap pulse and a saturating wrap counter.

---
 rtl/test_module_dff_pkg.sv | 14 +
 rtl/test_module_dff_dff_ar.sv | 17 +
 rtl/test_module_dff.sv | 95 +++++++++
 tb/tb_test_module_dff.sv | 139 +++++++++++++
 4 files changed

// File: rtl/test_module_dff_pkg.sv
// Shared constants, count type and Gray helper for test_module_dff.
// Optional build macro: TEST_MODULE_DFF_SATURATE_EN.
package test_module_dff_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_WRAP_W = 8;

  typedef logic [DEF_WIDTH-1:0] cnt_t;

  function automatic cnt_t bin2gray(input cnt_t b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/test_module_dff_dff_ar.sv
// Parameterised-width D flip-flop with asynchronous active-low clear.
// Building block for every register in test_module_dff.
module dff_ar #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else      q <= d;
  end

endmodule

// File: rtl/test_module_dff.sv
// Free-running up-counter with reset synchroniser, Gray/tc decodes and wrap count.
// Build macro TEST_MODULE_DFF_SATURATE_EN: count stops at all-ones instead of wrapping.
module test_module_dff
  import test_module_dff_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int WRAP_W = DEF_WRAP_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic [WIDTH-1:0]  count,
  output logic [WIDTH-1:0]  count_gray,
  output logic              tc,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_cnt
);

  logic              sync1;
  logic              run;
  logic              at_max;
  logic [WIDTH-1:0]  count_d;
  logic              wrap_d;
  logic [WRAP_W-1:0] wrap_cnt_d;

  // release path: constant 1 shifted through two flops
  dff_ar #(.W(1)) u_sync1 (
    .clk (clk),
    .rst (rst),
    .d   (1'b1),
    .q   (sync1)
  );

  dff_ar #(.W(1)) u_run (
    .clk (clk),
    .rst (rst),
    .d   (sync1),
    .q   (run)
  );

  dff_ar #(.W(WIDTH)) u_count (
    .clk (clk),
    .rst (rst),
    .d   (count_d),
    .q   (count)
  );

  dff_ar #(.W(1)) u_wrap (
    .clk (clk),
    .rst (rst),
    .d   (wrap_d),
    .q   (wrap)
  );

  dff_ar #(.W(WRAP_W)) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .d   (wrap_cnt_d),
    .q   (wrap_cnt)
  );

  assign at_max = (count == {WIDTH{1'b1}});
  assign tc     = at_max;

`ifdef TEST_MODULE_DFF_SATURATE_EN
  always_comb begin
    count_d    = count;
    wrap_d     = 1'b0;
    wrap_cnt_d = wrap_cnt;
    if (run && !at_max) count_d = count + 1'b1;
  end
`else
  always_comb begin
    count_d    = count;
    wrap_d     = 1'b0;
    wrap_cnt_d = wrap_cnt;
    if (run) begin
      count_d = count + 1'b1;
      if (at_max) begin
        wrap_d = 1'b1;
        if (wrap_cnt != {WRAP_W{1'b1}})
          wrap_cnt_d = wrap_cnt + 1'b1;
      end
    end
  end
`endif

  generate
    if (WIDTH == DEF_WIDTH) begin : g_gray_pkg
      assign count_gray = bin2gray(count);
    end else begin : g_gray_gen
      assign count_gray = count ^ (count >> 1);
    end
  endgenerate

endmodule

// File: tb/tb_test_module_dff.sv
// Randomised self-checking bench for test_module_dff.
// Model: outputs derived from the number of edges seen since reset release.
module tb_test_module_dff;

  logic       clk;
  logic       rst;
  logic [3:0] count;
  logic [3:0] count_gray;
  logic       tc;
  logic       wrap;
  logic [7:0] wrap_cnt;

  int checks;
  int failures;
  int k;

  logic [3:0] gtab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                            4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  test_module_dff dut (
    .clk        (clk),
    .rst        (rst),
    .count      (count),
    .count_gray (count_gray),
    .tc         (tc),
    .wrap       (wrap),
    .wrap_cnt   (wrap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // n = number of increment edges since release (edges 1-2 fill the synchroniser)
  task automatic check_all(input int n);
    int ec, ew, ewc;
`ifdef TEST_MODULE_DFF_SATURATE_EN
    ec  = (n > 15) ? 15 : n;
    ew  = 0;
    ewc = 0;
`else
    ec  = n % 16;
    ew  = (n > 0 && n % 16 == 0) ? 1 : 0;
    ewc = (n / 16 > 255) ? 255 : n / 16;
`endif
    check("count", int'(count), ec);
    check("count_gray", int'(count_gray), int'(gtab[ec]));
    check("tc", int'(tc), (ec == 15) ? 1 : 0);
    check("wrap", int'(wrap), ew);
    check("wrap_cnt", int'(wrap_cnt), ewc);
  endtask

  function automatic int incs(input int edges);
    return (edges > 2) ? edges - 2 : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    k++;
    #2;
    check_all(incs(k));
  endtask

  task automatic hold_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #2;
      check_all(0);
    end
  endtask

  task automatic release_rst(input int off);
    @(posedge clk);
    #(off);
    rst = 1'b1;
    k = 0;
  endtask

  task automatic async_reset(input string tag);
    rst = 1'b0;
    #1;
    check({tag, "_count"}, int'(count), 0);
    check({tag, "_wrap"}, int'(wrap), 0);
    check({tag, "_wrap_cnt"}, int'(wrap_cnt), 0);
    check({tag, "_tc"}, int'(tc), 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    k        = 0;
    rst      = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    check_all(0);
    hold_reset(2);

    // power-up release and free run past the first wrap
    release_rst(3);
    for (int i = 0; i < 22; i++) step();

    // asynchronous reset once the count reads 9
    for (int i = 0; i < 40 && (incs(k) % 16) != 9; i++) step();
    check("pre_reset_count", int'(count), (incs(k) % 16 == 9) ? 9 : -1);
    async_reset("mid");
    hold_reset(2);
    release_rst(4);
    for (int i = 0; i < 4; i++) step();

    // random run lengths, reset points and release phases
    for (int r = 0; r < 6; r++) begin
      int run_len, rst_off, hold, rel_off;
      run_len = int'($urandom_range(1, 40));
      rst_off = int'($urandom_range(1, 6));
      hold    = int'($urandom_range(1, 3));
      rel_off = int'($urandom_range(1, 8));
      for (int i = 0; i < run_len; i++) step();
      #(rst_off);
      async_reset("rnd");
      hold_reset(hold);
      release_rst(rel_off);
    end

    // long run: wrap counter saturates while count keeps wrapping
    for (int i = 0; i < 300 * 16 + 4; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
